// File: rtl/ex_div_pkg.sv
// rtl/ex_div_pkg.sv - shared state encodings and handshake levels for the execute-stage divider
package ex_div_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/ex_div.sv
// rtl/ex_div.sv - multi-cycle restoring signed/unsigned divider, one quotient bit per clock
module ex_div
    import ex_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    // Counter must reach WIDTH without wrapping.
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    div_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    // {partial remainder (WIDTH+1), dividend bits out / quotient bits in (WIDTH)}
    logic [2*WIDTH:0]     work_q, work_d;
    logic [WIDTH-1:0]     divisor_q, divisor_d;
    logic                 sgn_q, sgn_d;
    logic                 neg1_q, neg1_d;
    logic                 neg2_q, neg2_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;

    logic [WIDTH-1:0]     op1_abs;
    logic [WIDTH-1:0]     op2_abs;
    logic [WIDTH+1:0]     trial_diff;
    logic [WIDTH:0]       rem_shifted;
    logic [WIDTH-1:0]     quo_raw;
    logic [WIDTH-1:0]     rem_raw;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    // Magnitudes only differ from the raw operands for negative signed inputs.
    assign op1_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign op2_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    // Partial remainder shifted left with the next dividend bit brought in.
    assign rem_shifted = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};

    // One extra bit of headroom so the sign of the trial difference is always exact.
    assign trial_diff = {work_q[2*WIDTH:WIDTH], work_q[WIDTH-1]} - {2'b00, divisor_q};

    assign quo_raw = work_q[WIDTH-1:0];
    assign rem_raw = work_q[2*WIDTH-1:WIDTH];

    // Quotient negated when operand signs differ; remainder follows the dividend's sign.
    assign quo_fix = (sgn_q && (neg1_q ^ neg2_q)) ? -quo_raw : quo_raw;
    assign rem_fix = (sgn_q && neg1_q) ? -rem_raw : rem_raw;

    // State, datapath and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DivFree;
            cnt_q     <= '0;
            work_q    <= '0;
            divisor_q <= '0;
            sgn_q     <= 1'b0;
            neg1_q    <= 1'b0;
            neg2_q    <= 1'b0;
            result_q  <= '0;
            ready_q   <= DivResultNotReady;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            sgn_q     <= sgn_d;
            neg1_q    <= neg1_d;
            neg2_q    <= neg2_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    // Next-state and datapath updates for accept, shift-subtract, finish and release.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        sgn_d     = sgn_q;
        neg1_d    = neg1_q;
        neg2_d    = neg2_q;
        result_d  = result_q;
        ready_d   = ready_q;

        case (state_q)
            DivFree: begin
                if (start_i == DivStart && !annul_i) begin
                    sgn_d  = signed_div_i;
                    neg1_d = opdata1_i[WIDTH-1];
                    neg2_d = opdata2_i[WIDTH-1];
                    if (opdata2_i == '0) begin
                        state_d = DivByZero;
                    end else begin
                        state_d   = DivOn;
                        cnt_d     = '0;
                        work_d    = {{(WIDTH+1){1'b0}}, op1_abs};
                        divisor_d = op2_abs;
                    end
                end
            end

            DivByZero: begin
                if (annul_i) begin
                    state_d = DivFree;
                end else begin
                    state_d  = DivEnd;
                    result_d = '0;
                    ready_d  = DivResultReady;
                end
            end

            DivOn: begin
                if (annul_i) begin
                    state_d = DivFree;
                end else if (cnt_q != CNT_LAST) begin
                    if (!trial_diff[WIDTH+1]) begin
                        work_d = {trial_diff[WIDTH:0], work_q[WIDTH-2:0], 1'b1};
                    end else begin
                        work_d = {rem_shifted, work_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    state_d  = DivEnd;
                    result_d = {rem_fix, quo_fix};
                    ready_d  = DivResultReady;
                end
            end

            DivEnd: begin
                // Annul is ignored here; only dropping start releases the result.
                if (start_i == DivStop) begin
                    state_d  = DivFree;
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                end
            end

            default: begin
                state_d = DivFree;
            end
        endcase
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_ex_div.sv
// tb/tb_ex_div.sv - vector, random and corner-sequence checks for ex_div at WIDTH 32 and 8
module tb_ex_div;

    logic        clk;
    logic        rst;
    logic        sgn_div;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        start32;
    logic        start8;
    logic        annul;
    logic [63:0] result32;
    logic        ready32;
    logic [15:0] result8;
    logic        ready8;

    int n_pass;
    int n_total;

    ex_div #(.WIDTH(32)) u_dut32 (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (sgn_div),
        .opdata1_i    (opa),
        .opdata2_i    (opb),
        .start_i      (start32),
        .annul_i      (annul),
        .result_o     (result32),
        .ready_o      (ready32)
    );

    ex_div #(.WIDTH(8)) u_dut8 (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (sgn_div),
        .opdata1_i    (opa[7:0]),
        .opdata2_i    (opb[7:0]),
        .start_i      (start8),
        .annul_i      (annul),
        .result_o     (result8),
        .ready_o      (ready8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          w8;
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp_res;
        int          exp_edges;
        string       name;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    function automatic logic rdy(input bit w8);
        return w8 ? ready8 : ready32;
    endfunction

    function automatic logic [63:0] res(input bit w8);
        return w8 ? {48'b0, result8} : result32;
    endfunction

    // Reference: plain language division, truncating toward zero, computed in 64 bits.
    function automatic logic [63:0] model(input bit w8, input bit sgn,
                                          input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        logic [7:0] a8, b8;
        a8 = a[7:0];
        b8 = b[7:0];
        if (w8) begin
            if (b8 == 8'd0) return 64'd0;
            x = sgn ? longint'($signed(a8)) : longint'({56'b0, a8});
            y = sgn ? longint'($signed(b8)) : longint'({56'b0, b8});
            q = x / y;
            r = x % y;
            return {48'b0, r[7:0], q[7:0]};
        end
        if (b == 32'd0) return 64'd0;
        x = sgn ? longint'($signed(a)) : longint'({32'b0, a});
        y = sgn ? longint'($signed(b)) : longint'({32'b0, b});
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic do_start(input bit w8, input bit sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        sgn_div = sgn;
        opa     = a;
        opb     = b;
        if (w8) start8 = 1'b1;
        else    start32 = 1'b1;
    endtask

    // Counts edges from the accepting edge until ready is seen; bounded.
    task automatic wait_ready(input bit w8, output int edges);
        edges = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (rdy(w8)) break;
        end
    endtask

    task automatic release_div(input bit w8, input string name);
        if (w8) start8 = 1'b0;
        else    start32 = 1'b0;
        @(posedge clk);
        #1;
        check({name, " release ready"}, {63'b0, rdy(w8)}, 64'd0);
        check({name, " release result"}, res(w8), 64'd0);
    endtask

    task automatic run_vec(input bit w8, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp_res, input int exp_edges, input string name);
        int edges;
        do_start(w8, sgn, a, b);
        wait_ready(w8, edges);
        check({name, " latency"}, 64'(edges), 64'(exp_edges));
        check({name, " result"}, res(w8), exp_res);
        release_div(w8, name);
    endtask

    vec_t vecs[$];

    initial begin
        int edges;
        bit w8, s;
        logic [31:0] a, b;
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        sgn_div = 1'b0;
        opa     = '0;
        opb     = '0;
        start32 = 1'b0;
        start8  = 1'b0;
        annul   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset ready32", {63'b0, ready32}, 64'd0);
        check("reset result32", result32, 64'd0);
        check("reset ready8", {63'b0, ready8}, 64'd0);
        check("reset result8", {48'b0, result8}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        vecs.push_back('{0, 0, 32'd100, 32'd7, {32'h2, 32'hE}, 34, "u100/7"});
        vecs.push_back('{0, 1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 34, "s-7/2"});
        vecs.push_back('{0, 1, 32'd7, 32'hFFFFFFFE, {32'h1, 32'hFFFFFFFD}, 34, "s7/-2"});
        vecs.push_back('{0, 0, 32'd5, 32'd0, 64'd0, 2, "u5/0"});
        vecs.push_back('{0, 1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 34, "s32ovf"});
        vecs.push_back('{0, 0, 32'hFFFFFFFF, 32'd1, {32'h0, 32'hFFFFFFFF}, 34, "umax/1"});
        vecs.push_back('{0, 0, 32'd3, 32'd9, {32'h3, 32'h0}, 34, "u3/9"});
        vecs.push_back('{1, 1, 32'h80, 32'hFF, {48'h0, 8'h00, 8'h80}, 10, "s8ovf"});
        vecs.push_back('{1, 0, 32'hFF, 32'h10, {48'h0, 8'h0F, 8'h0F}, 10, "u8ff/10"});
        vecs.push_back('{1, 1, 32'hF9, 32'h02, {48'h0, 8'hFF, 8'hFD}, 10, "s8-7/2"});
        vecs.push_back('{1, 0, 32'h05, 32'h00, 64'd0, 2, "u8 5/0"});

        foreach (vecs[i])
            run_vec(vecs[i].w8, vecs[i].sgn, vecs[i].a, vecs[i].b,
                    vecs[i].exp_res, vecs[i].exp_edges, vecs[i].name);

        // Randomized operands against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            w8 = (i >= 24);
            s  = 1'($urandom_range(0, 1));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = $urandom_range(0, 15);
                2:       b = 32'hFFFFFFFF;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            if (w8) b[31:8] = '0;
            run_vec(w8, s, a, b, model(w8, s, a, b),
                    ((w8 ? b[7:0] : b) == 32'd0) ? 2 : (w8 ? 10 : 34), $sformatf("rnd%0d", i));
        end

        // Annul on the 10th DivOn cycle, then restart with new operands.
        do_start(0, 0, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        @(posedge clk);
        #1;
        check("annul ready low", {63'b0, ready32}, 64'd0);
        @(negedge clk);
        annul = 1'b0;
        opa   = 32'd9;
        opb   = 32'd3;
        wait_ready(0, edges);
        check("post-annul latency", 64'(edges), 64'd34);
        check("post-annul result", result32, {32'h0, 32'h3});
        // Annul while the result is held must be ignored.
        annul = 1'b1;
        @(posedge clk);
        #1;
        annul = 1'b0;
        check("annul in end ready", {63'b0, ready32}, 64'd1);
        check("annul in end result", result32, {32'h0, 32'h3});
        release_div(0, "post-annul");

        // Asynchronous reset mid-DivOn, then a normal division.
        do_start(0, 0, 32'd100, 32'd7);
        repeat (15) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst mid-op ready", {63'b0, ready32}, 64'd0);
        check("rst mid-op result", result32, 64'd0);
        @(negedge clk);
        rst     = 1'b0;
        start32 = 1'b0;
        run_vec(0, 0, 32'd9, 32'd3, {32'h0, 32'h3}, 34, "post-rst");

        // Asynchronous reset while a result is held clears outputs before any edge.
        do_start(0, 0, 32'd100, 32'd7);
        wait_ready(0, edges);
        check("pre-rst held result", result32, {32'h2, 32'hE});
        #2;
        rst = 1'b1;
        #1;
        check("async rst ready", {63'b0, ready32}, 64'd0);
        check("async rst result", result32, 64'd0);
        @(negedge clk);
        rst     = 1'b0;
        start32 = 1'b0;
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
